frame_scanout: RTL

FRAME_SCANOUT -- requirements
Module: frame_scanout

---
 rtl/scanout_pkg.sv | 31 +++
 rtl/scanout_fifo.sv | 54 +++++
 rtl/frame_scanout.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/scanout_pkg.sv
// Shared types and constants for the frame scanout block: timing defaults,
// line stride, FSM state encoding and the RGB555 -> RGB888 expansion.
package scanout_pkg;

  localparam int H_ACTIVE_DEF = 720;
  localparam int V_ACTIVE_DEF = 480;
  localparam int LINE_STRIDE  = 1024;
  localparam int LINE_SHIFT   = $clog2(LINE_STRIDE);
  localparam int ADDR_W       = 20;
  localparam int WORD_W       = 16;
  localparam int PIX_W        = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Word layout is {B5, G5, R5}; bit replication keeps full-scale at 0xFF.
  function automatic logic [PIX_W-1:0] rgb555_to_888(input logic [14:0] c);
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    r = c[4:0];
    g = c[9:5];
    b = c[14:10];
    return {r, r[4:2], g, g[4:2], b, b[4:2]};
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous pixel-word FIFO with occupancy count; power-of-two depth so the
// pointers wrap naturally.
module scanout_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees a slot in the same cycle, so push is allowed when full-and-popping.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_scanout.sv
// Frame scanout: fetches one frame of RGB555 words from memory and streams
// RGB888 pixels downstream. Optional mask blanking via SCANOUT_MASK_BLANK_EN.
module frame_scanout
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] base_addr,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [23:0] pix_data,
  output logic        pix_en,
  input  logic        pix_rdy,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  // Handshakes: a read is accepted on a cycle with mem_req && mem_gnt; mem_addr
  // holds while mem_req is high and mem_gnt low. Returns arrive in order on
  // mem_rvalid. Downstream, pix_en is a one-cycle strobe issued only when
  // pix_rdy is high, never on back-to-back cycles.

  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q;
  state_t            state_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  outst_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    inflight;
  logic [15:0]       fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              room;
  logic              grant;
  logic              last_px;
  logic              start_ok;
  logic              rv_ok;
  logic              pop;
  logic [23:0]       pixel_next;

  assign grant    = mem_req && mem_gnt;
  assign last_px  = (x_q == XW'(H_ACTIVE - 1)) && (y_q == YW'(V_ACTIVE - 1));
  assign start_ok = start && (state_q == IDLE);
  // Returns with nothing outstanding belong to an abandoned scan and are dropped.
  assign rv_ok    = mem_rvalid && (outst_q != '0);
  assign pop      = pix_rdy && !fifo_empty && !pix_en;
  assign inflight = {1'b0, fifo_count} + {1'b0, outst_q};
  assign room     = inflight < (CNT_W + 1)'(FIFO_DEPTH);
  assign mem_addr = base_q + (ADDR_W'(y_q) << LINE_SHIFT) + ADDR_W'(x_q);
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        mem_req = room;
        if (room && mem_gnt && last_px) state_d = DRAIN;
      end
      DRAIN: begin
        if ((outst_q == '0) && fifo_empty) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      outst_q <= '0;
    end else begin
      if (start_ok) begin
        x_q    <= '0;
        y_q    <= '0;
        base_q <= base_addr;
      end else if (grant) begin
        if (x_q == XW'(H_ACTIVE - 1)) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
      unique case ({grant, rv_ok})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rv_ok),
    .wdata (mem_rdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SCANOUT_MASK_BLANK_EN
  assign pixel_next = fifo_rdata[15] ? 24'h000000 : rgb555_to_888(fifo_rdata[14:0]);
`else
  logic unused_mask;
  assign unused_mask = fifo_rdata[15] | fifo_full;
  assign pixel_next  = rgb555_to_888(fifo_rdata[14:0]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en   <= 1'b0;
      pix_data <= '0;
    end else begin
      pix_en <= pop;
      if (pop) pix_data <= pixel_next;
    end
  end

endmodule
